handshake_elastic_fifo: RTL and testbench
=========================================

Name: handshake_elastic_fifo

Overview:
Registered elastic FIFO for dataflow handshake channels. It sits directly downstream of token producers such as handshake constants, forks and muxes. It decouples producer and consumer with FIFO_DEPTH slots of storage. It has no combinational path from outs_ready to ins_ready or from ins_valid to outs_valid, which breaks long valid/ready chains between elastic stages.

Parameters:
DATA_WIDTH, 32, width of the data token in bits
FIFO_DEPTH, 4, number of token slots; legal values ≥ 1, not restricted to powers of two

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
ins  input  DATA_WIDTH  input channel data
ins_valid  input  1  input channel valid
ins_ready  output  1  input channel ready
outs  output  DATA_WIDTH  output channel data
outs_valid  output  1  output channel valid
outs_ready  input  1  output channel ready

Behaviour:
- Interface, decided: one clock, clk; reset rst is asynchronous and active-high.
- State:
  - storage array mem[0..FIFO_DEPTH-1], DATA_WIDTH wide
  - head (read pointer) and tail (write pointer), each range 0..FIFO_DEPTH-1
  - count, width clog2(FIFO_DEPTH+1), range 0..FIFO_DEPTH
- Reset (rst=1, asynchronous, takes effect without waiting for a clk edge):
  - head=0, tail=0, count=0
  - therefore outs_valid=0 and ins_ready=1 while rst is held and immediately after
  - mem is not reset
  - rst asserted mid-operation discards all stored tokens; no token is emitted after release until a new push.
- Flags, combinational from registered state only:
  - full = (count==FIFO_DEPTH); empty = (count==0)
  - ins_ready = !full (no bypass on outs_ready)
  - outs_valid = !empty
  - outs = mem[head] at all times; outs is don't-care when outs_valid=0
- Transfers:
  - push = ins_valid && ins_ready
  - pop = outs_valid && outs_ready
- On clk rising edge with rst=0:
  - push: mem[tail] <= ins; tail <= (tail==FIFO_DEPTH-1) ? 0 : tail+1
  - pop: head <= (head==FIFO_DEPTH-1) ? 0 : head+1
  - count: +1 on push only; -1 on pop only; unchanged on both or neither
- Latency: a token pushed at edge N is visible on outs with outs_valid=1 in the cycle after edge N (1 cycle). There is no same-cycle pass-through when empty.
- Throughput: 1 token/cycle sustained when 0<count<FIFO_DEPTH and both sides are active.
- Boundary conditions:
  - Full: ins_ready=0, so no push. A pop in that cycle frees a slot, and ins_ready rises the following cycle.
  - Empty: outs_valid=0, so no pop. A push in that cycle makes outs_valid rise the following cycle.
  - Simultaneous push and pop at count=1: the count stays 1, outs advances to the newly pushed token, and ordering is preserved.
  - Wrap-around: pointers wrap at FIFO_DEPTH-1 to 0, including for non-power-of-two depths.
  - FIFO_DEPTH=1: behaves as a single-slot register. ins_ready and outs_valid are mutually exclusive, giving at most 1 token per 2 cycles.
- Ordering: strict FIFO. No token is dropped or duplicated.
- Stability: while outs_valid=1 and outs_ready=0, outs and outs_valid hold stable.
- No other outputs or side effects.

Test Plan:
1. Fill to full. DEPTH=4, outs_ready=0, push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → ins_ready=0 after the 4th edge. A 5th token 0x55 held valid is not accepted. outs=0x11 held stable.
2. Drain order. Continue from 1, assert outs_ready=1 for 4 cycles → outs sequence 0x11, 0x22, 0x33, 0x44. outs_valid=0 after the 4th pop. ins_ready rises one cycle after the first pop.
3. Streaming. ins_valid=1 with an incrementing counter 1..20, outs_ready=1 always → first outs_valid one cycle after the first push. Outputs are 1..20 on consecutive cycles with no bubbles; count never exceeds 1.
4. Wrap-around with non-power-of-two depth. DEPTH=3, random ins_valid/outs_ready at 50% each, 200 tokens → output sequence equals input sequence. Pointers observed passing 2→0 at least 10 times.
5. Reset mid-operation. With 3 tokens stored, assert rst between edges → outs_valid=0 and ins_ready=1 immediately, before the next clk edge. After release, pushing 0xAB makes outs=0xAB the next cycle, with no stale tokens emitted.
6. Single slot. DEPTH=1, ins_valid=1 and outs_ready=1 constantly with tokens 7, 8, 9 → outputs 7, 8, 9, one token every 2 cycles. ins_ready and outs_valid are never both 1.

Source files
------------

// File: rtl/handshake_elastic_fifo.sv
// Registered elastic FIFO for valid/ready handshake channels.
// Flags come only from registered state, so no combinational path exists
// from outs_ready to ins_ready or from ins_valid to outs_valid.
module handshake_elastic_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  // Pointer width is at least one bit so FIFO_DEPTH=1 still has a legal index.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Handshake flags and transfer qualifiers derived from registered state.
  always_comb begin
    full_s     = (count_q == CNT_FULL);
    empty_s    = (count_q == CNT_ZERO);
    ins_ready  = !full_s;
    outs_valid = !empty_s;
    outs       = mem_q[head_q];
    push_s     = ins_valid && ins_ready;
    pop_s      = outs_valid && outs_ready;
  end

  // Next-state for pointers (wrapping at FIFO_DEPTH-1) and occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (push_s) begin
      tail_d = (tail_q == LAST_PTR) ? PTR_ZERO : (tail_q + PTR_ONE);
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = (head_q == LAST_PTR) ? PTR_ZERO : (head_q + PTR_ONE);
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register; asynchronous reset discards all stored tokens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= PTR_ZERO;
      tail_q  <= PTR_ZERO;
      count_q <= CNT_ZERO;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Token storage; contents are not reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[tail_q] <= ins;
    end
  end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Self-checking bench: three FIFO instances (depth 4, 3 and 1) compared each
// cycle against a queue-based reference model, plus directed checks.
module tb_handshake_elastic_fifo;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: depth 4
  logic [DW-1:0] a_ins, a_outs;
  logic a_ins_valid, a_ins_ready, a_outs_valid, a_outs_ready;
  // Instance B: depth 3
  logic [DW-1:0] b_ins, b_outs;
  logic b_ins_valid, b_ins_ready, b_outs_valid, b_outs_ready;
  // Instance C: depth 1
  logic [DW-1:0] c_ins, c_outs;
  logic c_ins_valid, c_ins_ready, c_outs_valid, c_outs_ready;

  handshake_elastic_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
    .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready));
  handshake_elastic_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(3)) u_b (
    .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
    .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready));
  handshake_elastic_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(1)) u_c (
    .clk(clk), .rst(rst), .ins(c_ins), .ins_valid(c_ins_valid), .ins_ready(c_ins_ready),
    .outs(c_outs), .outs_valid(c_outs_valid), .outs_ready(c_outs_ready));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one queue of held tokens per instance.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] qc[$];
  bit pa, pb, pc, oa, ob, oc;
  int b_popcnt = 0;
  logic [DW-1:0] c_vals[$];
  int            c_cycs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_ins_ready", {31'd0, a_ins_ready}, {31'd0, qa.size() < 4});
    chk("a_outs_valid", {31'd0, a_outs_valid}, {31'd0, qa.size() > 0});
    if (qa.size() > 0) chk("a_outs", {24'd0, a_outs}, {24'd0, qa[0]});
    chk("b_ins_ready", {31'd0, b_ins_ready}, {31'd0, qb.size() < 3});
    chk("b_outs_valid", {31'd0, b_outs_valid}, {31'd0, qb.size() > 0});
    if (qb.size() > 0) chk("b_outs", {24'd0, b_outs}, {24'd0, qb[0]});
    chk("c_ins_ready", {31'd0, c_ins_ready}, {31'd0, qc.size() < 1});
    chk("c_outs_valid", {31'd0, c_outs_valid}, {31'd0, qc.size() > 0});
    if (qc.size() > 0) chk("c_outs", {24'd0, c_outs}, {24'd0, qc[0]});
    chk("c_exclusive", {31'd0, c_ins_ready && c_outs_valid}, 32'd0);
  endtask

  // One clock: decide transfers from the model, advance at the edge, check after.
  task automatic step();
    logic [DW-1:0] da, db, dc, v;
    pa = a_ins_valid && (qa.size() < 4);  oa = a_outs_ready && (qa.size() > 0);
    pb = b_ins_valid && (qb.size() < 3);  ob = b_outs_ready && (qb.size() > 0);
    pc = c_ins_valid && (qc.size() < 1);  oc = c_outs_ready && (qc.size() > 0);
    da = a_ins; db = b_ins; dc = c_ins;
    @(posedge clk);
    cyc++;
    if (oa) v = qa.pop_front();
    if (pa) qa.push_back(da);
    if (ob) begin v = qb.pop_front(); b_popcnt++; end
    if (pb) qb.push_back(db);
    if (oc) begin v = qc.pop_front(); c_vals.push_back(v); c_cycs.push_back(cyc); end
    if (pc) qc.push_back(dc);
    #1;
    check_all();
  endtask

  logic [DW-1:0] fill_tok [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] c_tok    [3] = '{8'h07, 8'h08, 8'h09};
  logic [DW-1:0] b_tok    [200];

  initial begin
    int bi, ci;
    rst = 1'b1;
    a_ins = '0; a_ins_valid = 1'b0; a_outs_ready = 1'b0;
    b_ins = '0; b_ins_valid = 1'b0; b_outs_ready = 1'b0;
    c_ins = '0; c_ins_valid = 1'b0; c_outs_ready = 1'b0;
    for (int i = 0; i < 200; i++) b_tok[i] = DW'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", {31'd0, a_outs_valid}, 32'd0);
    chk("rst_a_ready", {31'd0, a_ins_ready}, 32'd1);
    chk("rst_b_valid", {31'd0, b_outs_valid}, 32'd0);
    chk("rst_c_ready", {31'd0, c_ins_ready}, 32'd1);
    rst = 1'b0;

    // 1. Fill to full, output held stable
    a_ins_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_ins = fill_tok[i];
      step();
    end
    chk("fill_ready_low", {31'd0, a_ins_ready}, 32'd0);
    a_ins = 8'h55;
    step();
    step();
    chk("fill_no_accept", {31'd0, a_ins_ready}, 32'd0);
    chk("fill_hold_outs", {24'd0, a_outs}, 32'h11);
    chk("fill_hold_valid", {31'd0, a_outs_valid}, 32'd1);

    // 2. Drain in order
    a_ins_valid = 1'b0;
    a_outs_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_outs", {24'd0, a_outs}, {24'd0, fill_tok[i]});
      step();
      if (i == 0) chk("drain_ready_rise", {31'd0, a_ins_ready}, 32'd1);
    end
    chk("drain_empty", {31'd0, a_outs_valid}, 32'd0);

    // 3. Streaming with no bubbles
    a_ins_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      a_ins = DW'(k);
      step();
      chk("stream_valid", {31'd0, a_outs_valid}, 32'd1);
      chk("stream_outs", {24'd0, a_outs}, k);
      chk("stream_ready", {31'd0, a_ins_ready}, 32'd1);
    end
    a_ins_valid = 1'b0;
    step();
    chk("stream_drained", {31'd0, a_outs_valid}, 32'd0);

    // 5. Reset mid-operation with three tokens stored
    a_outs_ready = 1'b0;
    a_ins_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_ins = 8'hA1 + DW'(i);
      step();
    end
    a_ins_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst_valid", {31'd0, a_outs_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, a_ins_ready}, 32'd1);
    qa.delete(); qb.delete(); qc.delete();
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_empty", {31'd0, a_outs_valid}, 32'd0);
    a_ins = 8'hAB;
    a_ins_valid = 1'b1;
    step();
    chk("post_rst_outs", {24'd0, a_outs}, 32'hAB);
    a_ins_valid = 1'b0;
    a_outs_ready = 1'b1;
    step();
    chk("post_rst_no_stale", {31'd0, a_outs_valid}, 32'd0);
    a_outs_ready = 1'b0;

    // 4. Random traffic through the depth-3 instance
    bi = 0;
    for (int n = 0; n < 3000 && b_popcnt < 200; n++) begin
      b_ins_valid  = (bi < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      b_ins        = (bi < 200) ? b_tok[bi] : '0;
      b_outs_ready = 1'($urandom_range(0, 1));
      step();
      if (pb) bi++;
    end
    chk("rand_tokens_out", b_popcnt, 200);
    chk("rand_tokens_in", bi, 200);
    b_ins_valid = 1'b0;
    b_outs_ready = 1'b0;

    // 6. Single-slot behaviour
    ci = 0;
    c_outs_ready = 1'b1;
    for (int n = 0; n < 20 && c_vals.size() < 3; n++) begin
      c_ins_valid = (ci < 3);
      c_ins       = (ci < 3) ? c_tok[ci] : '0;
      step();
      if (pc) ci++;
    end
    chk("single_count", c_vals.size(), 3);
    if (c_vals.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("single_vals", {24'd0, c_vals[i]}, {24'd0, c_tok[i]});
      chk("single_spacing1", c_cycs[1] - c_cycs[0], 2);
      chk("single_spacing2", c_cycs[2] - c_cycs[1], 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
